// File: rtl/contador_bcd_pkg.sv
// contador_bcd_pkg
// Shared BCD constants and helpers for the contador_bcd_fd counter and its
// per-digit cells.
//   BCD_W        : width of one BCD digit
//   BCD_MAX      : largest legal digit value (9)
//   BCD_MIN      : smallest legal digit value (0)
//   bcd_sanitise : maps any non-decimal nibble (10..15) to 0, leaves 0..9 as-is
package contador_bcd_pkg;

    localparam int              BCD_W   = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
    localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

    // Loading a non-decimal nibble would leave a digit the counter can never
    // step out of cleanly, so such nibbles are forced to zero.
    function automatic logic [BCD_W-1:0] bcd_sanitise(input logic [BCD_W-1:0] nibble);
        return (nibble > BCD_MAX) ? BCD_MIN : nibble;
    endfunction

endpackage

// File: rtl/bcd_digito_fd.sv
// bcd_digito_fd
// One decimal digit of the up/down counter. Cells are chained so that the
// step_out of digit i is the step_in of digit i+1.
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : synchronous active-low reset, clears the digit
//   load       : synchronous load of load_digit (sanitised)
//   load_digit : raw nibble to load
//   step_in    : this digit takes one step on this edge
//   up         : 1 = increment, 0 = decrement
//   digit      : registered digit value
//   step_out   : carry (up, 9->0) or borrow (down, 0->9) into the next digit
module bcd_digito_fd
    import contador_bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [BCD_W-1:0] load_digit,
    input  logic             step_in,
    input  logic             up,
    output logic [BCD_W-1:0] digit,
    output logic             step_out
);

    // The digit only rolls over when it is actually stepping, so the
    // carry/borrow into the next digit is qualified by step_in.
    assign step_out = step_in && (up ? (digit == BCD_MAX) : (digit == BCD_MIN));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit <= BCD_MIN;
        end else if (load) begin
            digit <= bcd_sanitise(load_digit);
        end else if (step_in) begin
            if (up) begin
                digit <= (digit == BCD_MAX) ? BCD_MIN : digit + 4'd1;
            end else begin
                digit <= (digit == BCD_MIN) ? BCD_MAX : digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/contador_bcd_fd.sv
// contador_bcd_fd
// Multi-digit BCD up/down counter with prescaler, synchronous load and a
// free-running digit-scan multiplexer feeding a 7-segment decoder.
// Optional feature macro: CONTADOR_BCD_BLANK_EN (leading-zero blanking on
// dig_sel; counting is unaffected).
// Parameters:
//   N_DIG    : number of BCD digits (1..4)
//   DIV      : enabled cycles per count step (>=1)
//   SCAN_DIV : clock cycles each digit stays selected (>=1)
// Ports:
//   clk      : system clock, rising edge
//   rst_n    : synchronous active-low reset
//   en       : count enable, gates the prescaler
//   up       : 1 = increment, 0 = decrement
//   load     : synchronous load of load_val (has priority over counting)
//   load_val : packed BCD load value, digit0 in [3:0]
//   valor    : registered packed BCD count, digit0 in [3:0]
//   carry    : one-cycle pulse when valor wraps in either direction
//   bcd_mux  : currently scanned digit (bit3 -> decoder A ... bit0 -> D)
//   dig_sel  : one-hot active-high digit enable, bit i = digit i
module contador_bcd_fd
    import contador_bcd_pkg::*;
#(
    parameter int N_DIG    = 2,
    parameter int DIV      = 1,
    parameter int SCAN_DIV = 2
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   up,
    input  logic                   load,
    input  logic [BCD_W*N_DIG-1:0] load_val,
    output logic [BCD_W*N_DIG-1:0] valor,
    output logic                   carry,
    output logic [BCD_W-1:0]       bcd_mux,
    output logic [N_DIG-1:0]       dig_sel
);

    localparam int PW = (DIV > 1)      ? $clog2(DIV)      : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (N_DIG > 1)    ? $clog2(N_DIG)    : 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIG - 1);

    logic [PW-1:0]  prescaler;
    logic           step;
    logic [N_DIG:0] chain;
    logic [SW-1:0]  scan_cnt;
    logic [IW-1:0]  scan_idx;

    // A step happens on the edge where the prescaler sits at its last value
    // while enabled; load wins over counting so it suppresses the step.
    assign step     = en && !load && (prescaler == PRE_LAST);
    assign chain[0] = step;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else if (load) begin
            prescaler <= '0;
        end else if (en) begin
            prescaler <= (prescaler == PRE_LAST) ? '0 : prescaler + PW'(1);
        end
    end

    // The ripple out of the top digit is the wrap flag; registering it makes
    // carry line up with the cycle valor first shows the wrapped value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carry <= 1'b0;
        end else if (load) begin
            carry <= 1'b0;
        end else begin
            carry <= chain[N_DIG];
        end
    end

    for (genvar g = 0; g < N_DIG; g++) begin : g_digit
        bcd_digito_fd u_digit (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (load),
            .load_digit (load_val[BCD_W*g +: BCD_W]),
            .step_in    (chain[g]),
            .up         (up),
            .digit      (valor[BCD_W*g +: BCD_W]),
            .step_out   (chain[g+1])
        );
    end

    // Scan runs freely regardless of en/load/up so the display never stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IW'(1);
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

    // Digit select and mux are read straight from the registers so bcd_mux
    // and dig_sel change together. With blanking, the loop walks from the
    // top digit down, tracking whether everything from the current digit
    // upward is zero; digit0 is excluded so a plain 0 is still shown.
`ifdef CONTADOR_BCD_BLANK_EN
    logic hi_zero;
    logic blank;

    always_comb begin
        bcd_mux = '0;
        dig_sel = '0;
        hi_zero = 1'b1;
        blank   = 1'b0;
        for (int i = N_DIG - 1; i >= 0; i--) begin
            hi_zero = hi_zero && (valor[BCD_W*i +: BCD_W] == BCD_MIN);
            if (scan_idx == IW'(i)) begin
                bcd_mux    = valor[BCD_W*i +: BCD_W];
                dig_sel[i] = 1'b1;
                if ((i > 0) && hi_zero) begin
                    blank = 1'b1;
                end
            end
        end
        if (blank) begin
            dig_sel = '0;
        end
    end
`else
    always_comb begin
        bcd_mux = '0;
        dig_sel = '0;
        for (int i = 0; i < N_DIG; i++) begin
            if (scan_idx == IW'(i)) begin
                bcd_mux    = valor[BCD_W*i +: BCD_W];
                dig_sel[i] = 1'b1;
            end
        end
    end
`endif

endmodule
